// File: rtl/pb_evt_arb.sv
// pb_evt_arb: synchronises, debounces and edge-detects raw pushbuttons, latches
// presses as pending and grants them round-robin to one shared downstream port.
module pb_evt_arb #(
    parameter int NUM_PB    = 4,
    parameter int DB_CYCLES = 50000,
    parameter int IDW       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PB-1:0] pb,
    output logic              evt_valid,
    output logic [IDW-1:0]    evt_id,
    input  logic              evt_ready,
    output logic [NUM_PB-1:0] pending,
    output logic [7:0]        drop_cnt
);
    localparam int CNT_W = $clog2(DB_CYCLES);

    typedef enum logic {IDLE, OFFER} state_t;

    logic [NUM_PB-1:0] sync_p0, sync_p1;
    logic [CNT_W-1:0]  db_cnt [NUM_PB];
    logic [NUM_PB-1:0] stable, stable_d;
    logic [NUM_PB-1:0] rise, xfer_hit, drop_vec, pending_nxt;
    logic              xfer;
    state_t            state;
    logic [IDW-1:0]    rr_ptr;

    // Adds one per set bit to an 8-bit count, clamping at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] acc, input logic [NUM_PB-1:0] bits);
        logic [8:0] sum;
        sum = {1'b0, acc};
        for (int i = 0; i < NUM_PB; i++) begin
            sum = sum + {8'd0, bits[i]};
        end
        return (sum > 9'd255) ? 8'hFF : sum[7:0];
    endfunction

    // First requester at or above ptr, wrapping explicitly at NUM_PB-1.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_PB-1:0] req, input logic [IDW-1:0] ptr);
        logic [IDW-1:0] idx, pick;
        logic           found;
        idx   = ptr;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_PB; k++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = (idx == IDW'(NUM_PB - 1)) ? '0 : idx + IDW'(1);
        end
        return pick;
    endfunction

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= pb;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: a new level is accepted only after DB_CYCLES consecutive differing cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NUM_PB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < NUM_PB; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    stable[i] <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable & ~stable_d;
    assign xfer = evt_valid & evt_ready;

    always_comb begin
        xfer_hit = '0;
        if (xfer) begin
            xfer_hit[evt_id] = 1'b1;
        end
    end

    // A fresh press wins over the clear of the same button's transfer.
    assign pending_nxt = (pending & ~xfer_hit) | rise;
    assign drop_vec    = rise & pending & ~xfer_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            drop_cnt <= sat_add8(drop_cnt, drop_vec);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        evt_id    <= rr_pick(pending, rr_ptr);
                        evt_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        rr_ptr    <= (evt_id == IDW'(NUM_PB - 1)) ? '0 : evt_id + IDW'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pb_evt_arb.sv
// tb_pb_evt_arb: directed scenarios plus randomized pushbutton/ready traffic,
// compared every cycle against a behavioural model of the button-to-grant path.
module tb_pb_evt_arb;
    localparam int NUM_PB    = 4;
    localparam int DB_CYCLES = 4;
    localparam int IDW       = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_PB-1:0] pb = '0;
    logic              evt_ready = 1'b0;
    logic              evt_valid;
    logic [IDW-1:0]    evt_id;
    logic [NUM_PB-1:0] pending;
    logic [7:0]        drop_cnt;

    pb_evt_arb #(.NUM_PB(NUM_PB), .DB_CYCLES(DB_CYCLES), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .pb(pb), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ready(evt_ready), .pending(pending), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: button levels, press runs, pending set, offer and pointer
    int m_s1[NUM_PB], m_s2[NUM_PB], m_stab[NUM_PB], m_stab_d[NUM_PB], m_run[NUM_PB], m_pend[NUM_PB];
    int m_drop, m_valid, m_id, m_rr;
    int grants[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NUM_PB; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_stab_d[i] = 0; m_run[i] = 0; m_pend[i] = 0;
        end
        m_drop = 0; m_valid = 0; m_id = 0; m_rr = 0;
    endtask

    function automatic logic [31:0] m_pend_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < NUM_PB; i++) if (m_pend[i] != 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        int np[NUM_PB];
        int nid, nvalid, nrr, j;
        bit xfer, press, hit;
        xfer = (m_valid == 1) && (evt_ready == 1'b1);
        for (int i = 0; i < NUM_PB; i++) begin
            press = (m_stab[i] == 1) && (m_stab_d[i] == 0);
            hit   = xfer && (m_id == i);
            np[i] = hit ? 0 : m_pend[i];
            if (press) begin
                if (m_pend[i] == 1 && !hit) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                np[i] = 1;
            end
        end
        nid = m_id; nvalid = m_valid; nrr = m_rr;
        if (m_valid == 0) begin
            for (int k = 0; k < NUM_PB; k++) begin
                j = (m_rr + k) % NUM_PB;
                if (nvalid == 0 && m_pend[j] == 1) begin
                    nid = j; nvalid = 1;
                end
            end
        end else if (xfer) begin
            nvalid = 0;
            nrr = (m_id + 1) % NUM_PB;
        end
        for (int i = 0; i < NUM_PB; i++) begin
            m_stab_d[i] = m_stab[i];
            if (m_s2[i] != m_stab[i]) begin
                m_run[i]++;
                if (m_run[i] == DB_CYCLES) begin
                    m_stab[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(pb[i]);
            m_pend[i] = np[i];
        end
        m_id = nid; m_valid = nvalid; m_rr = nrr;
    endtask

    task automatic cycle();
        if (evt_valid === 1'b1 && evt_ready === 1'b1) grants.push_back(int'(evt_id));
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        chk("evt_valid", 32'(evt_valid), m_valid);
        chk("evt_id", 32'(evt_id), m_id);
        chk("pending", 32'(pending), m_pend_vec());
        chk("drop_cnt", 32'(drop_cnt), m_drop);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (evt_valid !== 1'b1 && n < max_cyc) begin
            cycle();
            n++;
        end
        chk(tag, 32'(evt_valid), 32'd1);
    endtask

    task automatic chk_grants(input string tag, input int exp[$]);
        chk({tag, "_count"}, grants.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(tag, (i < grants.size()) ? grants[i] : 99, exp[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_f, saw_valid, held_ok, hit;
        int hold[NUM_PB];
        m_reset();

        // 1: buttons held through reset, all four granted in index order
        pb = 4'hF;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_outputs", {evt_valid, 1'b0, evt_id, pending, drop_cnt}, 32'd0);
        end
        rst = 1'b1;
        evt_ready = 1'b1;
        grants.delete();
        seen_f = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (pending == 4'hF) seen_f = 1;
        end
        chk("t1_pending_all", 32'(seen_f), 32'd1);
        chk_grants("t1_grant", '{0, 1, 2, 3});
        pb = 4'h0;
        run(10);

        // 2: short glitch never becomes a press
        pb = 4'b0100;
        run(3);
        pb = 4'h0;
        saw_valid = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (evt_valid) saw_valid = 1;
        end
        chk("t2_pending", 32'(pending), 32'd0);
        chk("t2_no_valid", 32'(saw_valid), 32'd0);

        // 3: stalled offer held; second press of a pending button is dropped
        evt_ready = 1'b0;
        pb = 4'b0010;
        wait_valid("t3_valid", 30);
        chk("t3_id", 32'(evt_id), 32'd1);
        held_ok = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (!(evt_valid === 1'b1 && evt_id == 2'd1)) held_ok = 0;
        end
        chk("t3_offer_held", 32'(held_ok), 32'd1);
        pb = 4'h0;
        run(10);
        pb = 4'b0010;
        run(12);
        chk("t3_drop", 32'(drop_cnt), 32'd1);
        chk("t3_pending", 32'(pending), 32'b0010);
        pb = 4'h0;
        evt_ready = 1'b1;
        run(10);
        pb = 4'b0001;
        run(15);
        pb = 4'h0;
        run(10);

        // 4: pointer at 1 serves 3 before 0, and ends back at 1
        grants.delete();
        pb = 4'b1001;
        run(20);
        chk_grants("t4_grant", '{3, 0});
        pb = 4'h0;
        run(10);
        grants.delete();
        pb = 4'b0011;
        run(20);
        chk_grants("t4_ptr_grant", '{1, 0});
        pb = 4'h0;
        run(10);

        // 5: fresh press coinciding with its own transfer is kept
        evt_ready = 1'b0;
        pb = 4'b0010;
        wait_valid("t5_valid", 30);
        pb = 4'h0;
        run(10);
        pb = 4'b0010;
        hit = 0;
        for (int n = 0; n < 20 && !hit; n++) begin
            if (m_stab[1] == 1 && m_stab_d[1] == 0) begin
                evt_ready = 1'b1;
                hit = 1;
            end
            cycle();
        end
        evt_ready = 1'b0;
        chk("t5_rise_seen", 32'(hit), 32'd1);
        chk("t5_pending", 32'(pending), 32'b0010);
        chk("t5_drop", 32'(drop_cnt), 32'd1);
        chk("t5_idle", 32'(evt_valid), 32'd0);
        cycle();
        chk("t5_regrant_valid", 32'(evt_valid), 32'd1);
        chk("t5_regrant_id", 32'(evt_id), 32'd1);
        evt_ready = 1'b1;
        pb = 4'h0;
        run(10);

        // 6: reset in the middle of an offer, then drop counter saturation
        evt_ready = 1'b0;
        pb = 4'b0100;
        wait_valid("t6_valid", 30);
        rst = 1'b0;
        m_reset();
        #1;
        chk("t6_async_valid", 32'(evt_valid), 32'd0);
        chk("t6_async_pending", 32'(pending), 32'd0);
        chk("t6_async_drop", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        run(2);
        rst = 1'b1;
        run(2);
        chk("t6_drop_released", 32'(drop_cnt), 32'd0);
        for (int p = 0; p < 80; p++) begin
            pb = 4'hF;
            run(5);
            pb = 4'h0;
            run(5);
        end
        chk("t6_drop_sat", 32'(drop_cnt), 32'd255);

        // Randomized traffic from a clean reset
        rst = 1'b0;
        m_reset();
        run(2);
        rst = 1'b1;
        for (int i = 0; i < NUM_PB; i++) hold[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_PB; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    pb[i] = ~pb[i];
                    hold[i] = int'($urandom_range(1, 9));
                end
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
